// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default sizing for the instruction-memory loader
package loader_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, ERROR} state_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles of an outstanding write; expired flags the last allowed cycle
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory while holding the core in reset
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic              mem_valid,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] rem;
  logic [31:0] data;
  logic expired, go, too_big, hs, ack, last;
  assign go = start && (state == IDLE || state == DONE || state == ERROR);
  assign too_big = word_count > {1'b1, {ADDR_W{1'b0}}};
  assign hs = state == WAIT_WORD && word_valid;
  assign ack = state == WRITE && mem_valid;
  assign last = rem == {{ADDR_W{1'b0}}, 1'b1};
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .load(hs), .enable(mem_request), .expired(expired)
  );
  always_comb begin
    state_nx = state;
    if (go) state_nx = too_big ? ERROR : (word_count == '0 ? DONE : WAIT_WORD);
    else if (hs) state_nx = WRITE;
    else if (ack) state_nx = last ? DONE : WAIT_WORD;
    else if (state == WRITE && expired) state_nx = ERROR;
  end
  // addr saturates on the final word so the address never wraps past the top of memory
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      data <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        addr <= '0;
        rem <= too_big ? '0 : word_count;
      end
      if (hs) data <= word_data;
      if (ack) begin
        rem <= rem - 1'b1;
        if (!last) addr <= addr + 1'b1;
      end
    end
  assign word_ready = state == WAIT_WORD;
  assign mem_request = state == WRITE;
  assign mem_we_re = mem_request;
  assign mem_mask = mem_request ? 4'hF : 4'h0;
  assign mem_address = addr;
  assign mem_data_in = data;
  assign busy = word_ready || mem_request;
  assign done = state == DONE;
  assign error = state == ERROR;
  assign core_rst = !done;
endmodule
